// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master.
//   lsu_state_e : access sequencing states
//   F3_*        : funct3 encodings for access size / signedness
//   be_for()    : byte-enable pattern for a size at a byte offset. The result is
//                 8 bits wide: [3:0] are the lanes of the first word, [7:4] the
//                 lanes that spill into the next word for a misaligned access.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [7:0] be_for(input logic [2:0] funct3, input logic [1:0] off);
    logic [7:0] base;
    case (funct3)
      F3_B, F3_BU: base = 8'h01;
      F3_H, F3_HU: base = 8'h03;
      F3_W:        base = 8'h0F;
      default:     base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment and extension (purely combinational).
//   rdata0    : first (or only) word read
//   rdata1    : second word of a split access (don't-care otherwise)
//   off       : byte offset of the access within rdata0
//   funct3    : access size / signedness
//   load_data : selected lanes, sign- or zero-extended to 32 bits
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] lane;

  always_comb begin
    // Treat the two words as one 64-bit little-endian window so split and
    // non-split loads share the same shifter.
    lane = 32'({rdata1, rdata0} >> {off, 3'b000});
    case (funct3)
      F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
      F3_W:    load_data = lane;
      F3_BU:   load_data = {24'h0, lane[7:0]};
      F3_HU:   load_data = {16'h0, lane[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the pipeline MEM stage and a word-organised
// data memory. One access in flight; req_ready is high only in IDLE.
//   clk, reset                   : clock, synchronous active-high reset
//   req_valid/req_ready          : pipeline handshake, transfer when both high
//   req_we/req_funct3/req_addr/req_wdata : access description
//   resp_valid/resp_data/resp_err: one-cycle completion pulse with result
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : word request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata : memory grant and read data / write ack
// Handshake: a pipeline request transfers on a posedge where req_valid and
// req_ready are both high; a memory request transfers on a posedge where
// mem_req and mem_gnt are both high; mem_rvalid is only honoured in WAIT states.
// Build option MISALIGNED_SPLIT_EN: misaligned H/W accesses are split into two
// word accesses instead of completing with resp_err.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic              split_q, split_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic [1:0]          in_off;
  logic                in_legal, in_mis;
  logic [7:0]          be8;
  logic [2*DATA_W-1:0] wdata64;
  logic [ADDR_W-1:0]   word_addr;
  logic [DATA_W-1:0]   align_rdata0, load_data;

  // In WAIT1 the first word comes from the capture register and the live bus
  // carries the second word; otherwise the live bus is the first word.
  assign align_rdata0 = (state_q == WAIT1) ? rdata0_q : mem_rdata;

  lsu_load_align u_align (
    .rdata0    (align_rdata0),
    .rdata1    (mem_rdata),
    .off       (addr_q[1:0]),
    .funct3    (f3_q),
    .load_data (load_data)
  );

  always_comb begin
    in_off = req_addr[1:0];
    case (req_funct3)
      F3_B, F3_H, F3_W: in_legal = 1'b1;
      F3_BU, F3_HU:     in_legal = !req_we;
      default:          in_legal = 1'b0;
    endcase
    in_mis = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && (in_off == 2'd3)) ||
             ((req_funct3 == F3_W) && (in_off != 2'd0));

    // Lane layout of the captured access, used for the second word of a split.
    be8       = be_for(f3_q, addr_q[1:0]);
    wdata64   = {{DATA_W{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
    word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    split_d      = split_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!in_legal || (in_mis && !SPLIT_EN)) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d     = REQ0;
            split_d     = in_mis;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = 4'(be_for(req_funct3, in_off));
            mem_wdata_d = DATA_W'({{DATA_W{1'b0}}, req_wdata} << {in_off, 3'b000});
          end
        end
      end
      REQ0: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT0;
        end
      end
      WAIT0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
          if (split_q) begin
            state_d     = REQ1;
            mem_req_d   = 1'b1;
            mem_addr_d  = word_addr + ADDR_W'(4);
            mem_be_d    = be8[7:4];
            mem_wdata_d = wdata64[2*DATA_W-1:DATA_W];
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b0;
            resp_data_d  = we_q ? '0 : load_data;
          end
        end
      end
      REQ1: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = WAIT1;
        end
      end
      WAIT1: begin
        if (mem_rvalid) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = we_q ? '0 : load_data;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      split_q      <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      split_q      <= split_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a table of access vectors with
// hand-computed memory-side and response-side expectations, plus hand-written
// sequences for grant stalls with bus noise and reset in the middle of an access.
// Build option MISALIGNED_SPLIT_EN selects the split-access expectations.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n_mem;
    logic [31:0] a0, a1;
    logic [3:0]  b0, b1;
    logic [31:0] w0, w1;
    logic [31:0] r0, r1;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int n_mem,
                              input logic [31:0] a0, input logic [3:0] b0,
                              input logic [31:0] w0, input logic [31:0] r0,
                              input logic [31:0] a1, input logic [3:0] b1,
                              input logic [31:0] w1, input logic [31:0] r1,
                              input logic [31:0] data, input logic err);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.n_mem = n_mem; v.a0 = a0; v.b0 = b0; v.w0 = w0; v.r0 = r0;
    v.a1 = a1; v.b1 = b1; v.w1 = w1; v.r1 = r1; v.data = data; v.err = err;
    return v;
  endfunction

  // Issue one access, play the memory with grant delay d, check every cycle.
  // With noise set, the bench also re-presents req_valid while busy, grants
  // while mem_req is low and pulses rvalid while a request is pending.
  task automatic run_access(input vec_t v, input int d, input bit noise);
    int g, r, wait_cnt, resp_cnt, exp_lat;
    bit pending;
    exp_lat = (v.n_mem == 0) ? 1 : 1 + v.n_mem * (2 + d);
    @(negedge clk);
    chk({v.name, ".ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    g = 0; r = 0; wait_cnt = 0; resp_cnt = 0; pending = 1'b0;
    for (int c = 1; c <= 60 && resp_cnt == 0; c++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      if (noise) begin
        req_valid = 1'b1; req_addr = 32'hDEAD0001; req_we = ~v.we; req_funct3 = F3_W;
      end else begin
        req_valid = 1'b0;
      end
      chk({v.name, ".ready_busy"}, req_ready, 1'b0);
      if (pending) begin
        mem_rvalid = 1'b1; mem_rdata = (r == 0) ? v.r0 : v.r1;
        r++; pending = 1'b0;
      end else if (noise && mem_req && wait_cnt != d) begin
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
      end
      if (resp_valid) begin
        resp_cnt++;
        req_valid = 1'b0;
        chk({v.name, ".resp_data"}, resp_data, v.data);
        chk({v.name, ".resp_err"}, resp_err, v.err);
        chk({v.name, ".latency"}, c, exp_lat);
      end else if (mem_req) begin
        chk({v.name, ".mem_req_expected"}, 1'b1, (g < v.n_mem) ? 1'b1 : 1'b0);
        if (g < v.n_mem) begin
          chk({v.name, ".mem_addr"}, mem_addr, (g == 0) ? v.a0 : v.a1);
          chk({v.name, ".mem_be"}, mem_be, (g == 0) ? v.b0 : v.b1);
          chk({v.name, ".mem_wdata"}, mem_wdata, (g == 0) ? v.w0 : v.w1);
          chk({v.name, ".mem_we"}, mem_we, v.we);
        end
        if (wait_cnt == d) begin
          mem_gnt = 1'b1; pending = 1'b1; wait_cnt = 0; g++;
        end else begin
          wait_cnt++;
        end
      end else if (noise) begin
        mem_gnt = 1'b1;
      end
    end
    chk({v.name, ".resp_count"}, resp_cnt, 1);
    chk({v.name, ".mem_count"}, g, v.n_mem);
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk({v.name, ".resp_pulse_end"}, resp_valid, 1'b0);
    chk({v.name, ".ready_after"}, req_ready, 1'b1);
    chk({v.name, ".mem_req_after"}, mem_req, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    //            name       we   f3      addr          wdata     n  a0            b0       w0            r0            a1            b1       w1            r1            data          err
    vecs.push_back(mk("sw",    1, F3_W,   32'h104, 32'h12345678, 1, 32'h104, 4'b1111, 32'h12345678, 32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk("sb",    1, F3_B,   32'h10A, 32'h000000AB, 1, 32'h108, 4'b0100, 32'h00AB0000, 32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk("lb",    0, F3_B,   32'h10A, 32'h0,        1, 32'h108, 4'b0100, 32'h0,        32'h00AB0000, 32'h0, 4'b0, 32'h0, 32'h0,        32'hFFFFFFAB, 0));
    vecs.push_back(mk("lbu",   0, F3_BU,  32'h10A, 32'h0,        1, 32'h108, 4'b0100, 32'h0,        32'h00AB0000, 32'h0, 4'b0, 32'h0, 32'h0,        32'h000000AB, 0));
    vecs.push_back(mk("lh",    0, F3_H,   32'h102, 32'h0,        1, 32'h100, 4'b1100, 32'h0,        32'h80010000, 32'h0, 4'b0, 32'h0, 32'h0,        32'hFFFF8001, 0));
    vecs.push_back(mk("lhu",   0, F3_HU,  32'h102, 32'h0,        1, 32'h100, 4'b1100, 32'h0,        32'h80010000, 32'h0, 4'b0, 32'h0, 32'h0,        32'h00008001, 0));
    vecs.push_back(mk("lb_pos",0, F3_B,   32'h101, 32'h0,        1, 32'h100, 4'b0010, 32'h0,        32'h00007F00, 32'h0, 4'b0, 32'h0, 32'h0,        32'h0000007F, 0));
    vecs.push_back(mk("sh",    1, F3_H,   32'h106, 32'hBEEF1234, 1, 32'h104, 4'b1100, 32'h12340000, 32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        0));
    vecs.push_back(mk("lw",    0, F3_W,   32'h200, 32'h0,        1, 32'h200, 4'b1111, 32'h0,        32'hDEADBEEF, 32'h0, 4'b0, 32'h0, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk("f3_011",0, 3'b011, 32'h100, 32'h0,        0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
    vecs.push_back(mk("st_bu", 1, F3_BU,  32'h100, 32'h55,       0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
    vecs.push_back(mk("f3_111",0, 3'b111, 32'h100, 32'h0,        0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
`ifdef MISALIGNED_SPLIT_EN
    vecs.push_back(mk("lw_mis",0, F3_W,   32'h0FE, 32'h0,        2, 32'h0FC, 4'b1100, 32'h0,        32'hBBBB0000, 32'h100, 4'b0011, 32'h0, 32'h0000AAAA, 32'hAAAABBBB, 0));
    vecs.push_back(mk("lh_mis",0, F3_H,   32'h103, 32'h0,        2, 32'h100, 4'b1000, 32'h0,        32'h12000000, 32'h104, 4'b0001, 32'h0, 32'h000000F3, 32'hFFFFF312, 0));
    vecs.push_back(mk("sw_mis",1, F3_W,   32'h0FD, 32'hA1B2C3D4, 2, 32'h0FC, 4'b1110, 32'hB2C3D400, 32'h0,        32'h100, 4'b0001, 32'h000000A1, 32'h0, 32'h0,      0));
    vecs.push_back(mk("lw_wrap",0,F3_W,   32'hFFFFFFFE, 32'h0,   2, 32'hFFFFFFFC, 4'b1100, 32'h0,   32'h11110000, 32'h0, 4'b0011, 32'h0, 32'h00002222, 32'h22221111, 0));
`else
    vecs.push_back(mk("lw_mis",0, F3_W,   32'h0FE, 32'h0,        0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
    vecs.push_back(mk("lh_mis",0, F3_H,   32'h103, 32'h0,        0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
    vecs.push_back(mk("sw_mis",1, F3_W,   32'h0FD, 32'hA1B2C3D4, 0, 32'h0,   4'b0,    32'h0,        32'h0,        32'h0, 4'b0, 32'h0, 32'h0,        32'h0,        1));
`endif

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.resp_data", resp_data, 32'h0);
    chk("rst.resp_err", resp_err, 1'b0);
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", mem_be, 4'b0000);
    chk("rst.mem_wdata", mem_wdata, 32'h0);

    // Table with immediate grants.
    foreach (vecs[i]) run_access(vecs[i], 0, 1'b0);

    // Grant withheld three cycles, with busy-time bus noise.
    run_access(vecs[0], 3, 1'b1);
    run_access(vecs[4], 3, 1'b1);
    run_access(vecs[12], 3, 1'b1);
    run_access(vecs[9], 2, 1'b1);

    // Reset asserted while waiting for read data; the late rvalid must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h300; req_wdata = 32'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.mem_req_on", mem_req, 1'b1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstmid.in_wait_mem_req", mem_req, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.mem_req_off", mem_req, 1'b0);
    chk("rstmid.ready", req_ready, 1'b1);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rstmid.no_resp", resp_valid, 1'b0);
      chk("rstmid.ready_hold", req_ready, 1'b1);
    end

    // The block must still work normally after the aborted access.
    run_access(vecs[2], 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
